rc4_stream_cipher: RTL

- Parametrised RC4 stream-cipher core; successor to the fixed 16-byte-key rc4_new_design.
- Accepts a key of runtime length 1..MAX_KEY_BYTES and runs KSA, with an optional RC4-drop[n] discard phase.
- Then XORs an unbounded valid/ready byte stream with keystream, one byte per cycle.
- Sits between the host key/config registers and the byte-stream datapath.

---
 rtl/rc4_stream_cipher.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/rc4_stream_cipher.sv
// RC4 stream cipher core: runtime-length key setup, optional drop phase, valid/ready byte XOR.
// Optional keystream tap ports (ks_byte, ks_count) are enabled by defining RC4_KEYSTREAM_TAP_EN.
module rc4_stream_cipher #(
    parameter int unsigned MAX_KEY_BYTES = 16,
    parameter int unsigned DROP_N        = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [MAX_KEY_BYTES*8-1:0] key,
    input  logic [7:0]                 key_length,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [7:0]                 out_data,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       key_err,
    output logic                       done
`ifdef RC4_KEYSTREAM_TAP_EN
    ,
    output logic [7:0]                 ks_byte,
    output logic [31:0]                ks_count
`endif
);

    typedef enum logic [2:0] {StIdle, StInit, StKsa, StDrop, StPrga} state_e;

    localparam logic [7:0]  MaxLen   = 8'(MAX_KEY_BYTES);
    localparam logic [15:0] DropLast = 16'(DROP_N - 1);

    state_e                     state_q, state_d;
    logic [7:0]                 s_q [256];
    logic [7:0]                 i_q, j_q, kidx_q, len_q;
    logic [15:0]                cnt_q;
    logic [MAX_KEY_BYTES*8-1:0] key_q;
    logic                       out_valid_q, out_last_q, last_seen_q, key_err_q, done_q;
    logic [7:0]                 out_data_q;

    logic       len_ok, start_ok, in_xfer, out_xfer, swap_en;
    logic [7:0] key_byte, ip, jp, si, sj, t, ks;

    assign len_ok   = (key_length != 8'd0) && (key_length <= MaxLen);
    assign start_ok = (state_q == StIdle) && start && len_ok;
    assign in_ready = (state_q == StPrga) && !last_seen_q && (!out_valid_q || out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;
    assign swap_en  = (state_q == StKsa) || (state_q == StDrop) || in_xfer;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != StIdle);
    assign key_err   = key_err_q;
    assign done      = done_q;

    always_comb begin
        key_byte = 8'd0;
        for (int unsigned b = 0; b < MAX_KEY_BYTES; b++) begin
            if (kidx_q == 8'(b)) key_byte = key_q[b*8 +: 8];
        end
    end

    // Shared swap datapath: KSA walks n with a key addend, DROP/PRGA walk i+1 with none.
    always_comb begin
        ip = (state_q == StKsa) ? cnt_q[7:0] : i_q + 8'd1;
        si = s_q[ip];
        jp = j_q + si + ((state_q == StKsa) ? key_byte : 8'd0);
        sj = s_q[jp];
        t  = si + sj;
        // S[t] is read after the swap, so the two swapped slots are forwarded.
        if (t == ip)      ks = sj;
        else if (t == jp) ks = si;
        else              ks = s_q[t];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start_ok) state_d = StInit;
            StInit: if (cnt_q[7:0] == 8'hFF) state_d = StKsa;
            StKsa:  if (cnt_q[7:0] == 8'hFF) state_d = (DROP_N == 0) ? StPrga : StDrop;
            StDrop: if (cnt_q == DropLast) state_d = StPrga;
            StPrga: if (out_xfer && out_last_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // S-box carries no reset; it is fully rewritten by INIT before use.
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            s_q[cnt_q[7:0]] <= cnt_q[7:0];
        end else if (swap_en) begin
            s_q[ip] <= sj;
            s_q[jp] <= si;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_q         <= 8'd0;
            j_q         <= 8'd0;
            kidx_q      <= 8'd0;
            len_q       <= 8'd0;
            cnt_q       <= 16'd0;
            key_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            out_last_q  <= 1'b0;
            last_seen_q <= 1'b0;
            key_err_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            key_err_q <= (state_q == StIdle) && start && !len_ok;
            done_q    <= out_xfer && out_last_q;

            if (state_d != state_q) cnt_q <= 16'd0;
            else if (state_q inside {StInit, StKsa, StDrop}) cnt_q <= cnt_q + 16'd1;

            case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        key_q       <= key;
                        len_q       <= key_length;
                        kidx_q      <= 8'd0;
                        i_q         <= 8'd0;
                        j_q         <= 8'd0;
                        last_seen_q <= 1'b0;
                    end
                end
                StKsa: begin
                    j_q    <= (cnt_q[7:0] == 8'hFF) ? 8'd0 : jp;
                    i_q    <= 8'd0;
                    kidx_q <= (kidx_q == len_q - 8'd1) ? 8'd0 : kidx_q + 8'd1;
                end
                StDrop: begin
                    i_q <= ip;
                    j_q <= jp;
                end
                StPrga: begin
                    if (in_xfer) begin
                        i_q <= ip;
                        j_q <= jp;
                        if (in_last) last_seen_q <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (in_xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= in_data ^ ks;
                out_last_q  <= in_last;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef RC4_KEYSTREAM_TAP_EN
    logic [7:0]  ks_byte_q;
    logic [31:0] ks_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ks_byte_q  <= 8'd0;
            ks_count_q <= 32'd0;
        end else if (start_ok) begin
            ks_count_q <= 32'd0;
        end else if (in_xfer) begin
            ks_byte_q  <= ks;
            ks_count_q <= ks_count_q + 32'd1;
        end
    end

    assign ks_byte  = ks_byte_q;
    assign ks_count = ks_count_q;
`endif

endmodule
